// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity/stop) feeding a FWFT FIFO.
// Ports: clk_in, rst_n_in, rx_in | data_out, valid_out, ready_in,
//   count_out | framing_err_out, parity_err_out, overflow_out,
//   clear_err_in (sticky error flags and their clear).
module uart_rx_fifo #(
  parameter int BAUD_COUNT = 645,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        rx_in,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [$clog2(FIFO_DEPTH):0] count_out,
  output logic                        framing_err_out,
  output logic                        parity_err_out,
  output logic                        overflow_out,
  input  logic                        clear_err_in
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_COUNT);
  localparam logic [CW-1:0] HALF = CW'(BAUD_COUNT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_COUNT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 2);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                 rx_meta, rx;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad, stop_bad;
  logic                 sample, frame_end, stop_fail;
  logic                 push_q, ferr_q, perr_q;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count_q;
  logic                 full, do_pop, do_push, ovf_set;

  assign stop_fail = stop_bad || !rx;

  always_comb begin
    state_d   = state_q;
    sample    = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (cnt == HALF) begin
          sample  = 1'b1;
          state_d = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == LAST_CNT) begin
          sample = 1'b1;
          if (bit_idx == LAST_DATA)
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (cnt == LAST_CNT) begin
          sample  = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == LAST_CNT) begin
          sample = 1'b1;
          if (bit_idx == LAST_STOP) begin
            frame_end = 1'b1;
            state_d   = stop_fail ? S_WAIT : S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta  <= 1'b1;
      rx       <= 1'b1;
      state_q  <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx      <= rx_meta;
      state_q <= state_d;
      if (state_q == S_IDLE || sample) cnt <= '0;
      else cnt <= cnt + 1'b1;
      // bit_idx restarts whenever a sample moves us to a new state
      if (state_q == S_IDLE) bit_idx <= '0;
      else if (sample)
        bit_idx <= (state_d != state_q) ? '0 : bit_idx + 1'b1;
      if (state_q == S_DATA && sample)
        shift <= {rx, shift[DATA_BITS-1:1]};
      if (state_q == S_IDLE) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (state_q == S_PAR && sample)
        par_bad <= ^shift ^ rx ^ ODD;
      if (state_q == S_STOP && sample && !rx)
        stop_bad <= 1'b1;
      push_q <= frame_end && !stop_fail && !par_bad;
      ferr_q <= frame_end && stop_fail;
      perr_q <= frame_end && par_bad;
    end
  end

  assign full    = (count_q == FULL_CNT);
  assign do_pop  = (count_q != '0) && ready_in;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push_q && (!full || do_pop);
  assign ovf_set = push_q && full && !do_pop;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      framing_err_out <= 1'b0;
      parity_err_out  <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      if (ferr_q) framing_err_out <= 1'b1;
      else if (clear_err_in) framing_err_out <= 1'b0;
      if (perr_q) parity_err_out <= 1'b1;
      else if (clear_err_in) parity_err_out <= 1'b0;
      if (ovf_set) overflow_out <= 1'b1;
      else if (clear_err_in) overflow_out <= 1'b0;
    end
  end

  assign data_out  = mem[rd_ptr];
  assign valid_out = (count_q != '0);
  assign count_out = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8N1 and 8E1 instances against a queue model.
// Frames are built bit by bit from the line protocol.
module tb_uart_rx_fifo;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       ready = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] data0, data_p;
  logic       valid0, valid_p;
  logic [2:0] cnt0, cnt_p;
  logic       fe0, pe0, ov0, fe_p, pe_p, ov_p;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .BAUD_COUNT(BAUD), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx),
    .data_out(data0), .valid_out(valid0), .ready_in(ready),
    .count_out(cnt0), .framing_err_out(fe0),
    .parity_err_out(pe0), .overflow_out(ov0),
    .clear_err_in(clr)
  );

  uart_rx_fifo #(
    .BAUD_COUNT(BAUD), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_p (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx_p),
    .data_out(data_p), .valid_out(valid_p), .ready_in(ready),
    .count_out(cnt_p), .framing_err_out(fe_p),
    .parity_err_out(pe_p), .overflow_out(ov_p),
    .clear_err_in(clr)
  );

  // start, LSB-first data, optional parity, one stop bit
  task automatic send_frame(input logic [7:0] d, input logic sel,
                            input logic pen, input logic pbit,
                            input logic stop_v);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    n = 9;
    if (pen) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = stop_v;
    n = n + 1;
    for (int i = 0; i < n; i++) begin
      if (sel) rx_p = bits[i];
      else rx = bits[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid0, cnt0, data0} !== 12'h0) begin
      errors++;
      $display("FAIL reset_out: got v=%b c=%0d d=%h want 0",
               valid0, cnt0, data0);
    end
    checks++;
    if ({fe0, pe0, ov0, fe_p, pe_p, ov_p, valid_p} !== 7'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
               {fe0, pe0, ov0, fe_p, pe_p, ov_p, valid_p});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int vcyc, first, maxc;
    logic [7:0] got;
    vcyc = 0;
    first = 0;
    maxc = 0;
    got = 8'h00;
    ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= BAUD * 10 + 8; i++) begin
        @(negedge clk);
        if (valid0) begin
          vcyc++;
          if (first == 0) begin
            first = i;
            got = data0;
          end
        end
        if (int'(cnt0) > maxc) maxc = int'(cnt0);
      end
    join
    ready = 1'b0;
    lat = (first == 0) ? 157 : first;
    checks++;
    if (vcyc !== 1) begin
      errors++;
      $display("FAIL single_valid_cycles: got %0d want 1", vcyc);
    end
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h want a5", got);
    end
    checks++;
    if (maxc !== 1 || cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL single_count: peak %0d end %0d want 1/0",
               maxc, cnt0);
    end
    // stop bit mid-point is negedge 152; allow sync + push latency
    checks++;
    if (first < 152 || first > 160) begin
      errors++;
      $display("FAIL single_latency: got %0d want 152..160", first);
    end
    checks++;
    if ({fe0, pe0, ov0} !== 3'b000) begin
      errors++;
      $display("FAIL single_flags: got %b want 000", {fe0, pe0, ov0});
    end
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    checks++;
    if ({valid0, fe0, pe0, ov0} !== 4'b0000) begin
      errors++;
      $display("FAIL false_start: got %b want 0000",
               {valid0, fe0, pe0, ov0});
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if ({valid0, cnt0, data0} !== {1'b1, 3'd1, 8'h3C}) begin
      errors++;
      $display("FAIL after_false_start: got v=%b c=%0d d=%h want 1/1/3c",
               valid0, cnt0, data0);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("FAIL pop_one: got valid=%b want 0", valid0);
    end
  endtask

  task automatic test_overflow();
    logic ovf_m;
    logic [7:0] exp;
    int npop;
    ovf_m = 1'b0;
    npop = 0;
    q.delete();
    ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b0, 1'b0, 1'b0, 1'b1);
      if (q.size() < DEPTH) q.push_back(8'(v));
      else ovf_m = 1'b1;
    end
    repeat (BAUD) @(negedge clk);
    checks++;
    if (int'(cnt0) !== q.size() || ov0 !== ovf_m) begin
      errors++;
      $display("FAIL ovf_state: got c=%0d ov=%b want %0d/%b",
               cnt0, ov0, q.size(), ovf_m);
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (valid0) begin
        npop++;
        exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++;
        if (data0 !== exp) begin
          errors++;
          $display("FAIL ovf_drain: got %h want %h", data0, exp);
        end
      end
      @(negedge clk);
    end
    ready = 1'b0;
    checks++;
    if (npop !== 4 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pops: got %0d v=%b want 4/0", npop, valid0);
    end
    clear_pulse();
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", ov0);
    end
  endtask

  task automatic test_framing();
    ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if ({valid0, fe0, pe0} !== 3'b010) begin
      errors++;
      $display("FAIL framing_set: got v/fe/pe=%b want 010",
               {valid0, fe0, pe0});
    end
    rx = 1'b1;
    repeat (BAUD * 12) @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL framing_guard: got v=%b c=%0d want 0/0",
               valid0, cnt0);
    end
    clear_pulse();
    checks++;
    if (fe0 !== 1'b0) begin
      errors++;
      $display("FAIL framing_clear: got %b want 0", fe0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if ({valid_p, pe_p, fe_p} !== 3'b010) begin
      errors++;
      $display("FAIL parity_bad: got v/pe/fe=%b want 010",
               {valid_p, pe_p, fe_p});
    end
    clear_pulse();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if ({valid_p, cnt_p, data_p, pe_p} !== {1'b1, 3'd1, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL parity_good: got v=%b c=%0d d=%h pe=%b want 1/1/07/0",
               valid_p, cnt_p, data_p, pe_p);
    end
    d = 8'($urandom);
    send_frame(d, 1'b1, 1'b1, 1'(($countones(d) % 2) == 1), 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (cnt_p !== 3'd2 || pe_p !== 1'b0) begin
      errors++;
      $display("FAIL parity_rand: got c=%0d pe=%b want 2/0", cnt_p, pe_p);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (data_p !== d || valid_p !== 1'b1) begin
      errors++;
      $display("FAIL parity_second: got %h want %h", data_p, d);
    end
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid_p !== 1'b0) begin
      errors++;
      $display("FAIL parity_drain: got v=%b want 0", valid_p);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (BAUD) @(negedge clk);
    rx = 1'b0;
    repeat (BAUD * 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid0, cnt0, data0, fe0, pe0, ov0} !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b c=%0d d=%h want 0",
               valid0, cnt0, data0);
    end
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BAUD * 10) @(negedge clk);
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: got v=%b want 0", valid0);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if ({valid0, cnt0, data0} !== {1'b1, 3'd1, 8'h5A}) begin
      errors++;
      $display("FAIL reset_recover: got c=%0d d=%h want 1/5a",
               cnt0, data0);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    int npop;
    npop = 0;
    q.delete();
    ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'($urandom);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
      q.push_back(d);
    end
    d = 8'($urandom);
    fork
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(d);
    checks++;
    if (cnt0 !== 3'd4 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: got c=%0d ov=%b want 4/0", cnt0, ov0);
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (valid0) begin
        npop++;
        d = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++;
        if (data0 !== d) begin
          errors++;
          $display("FAIL full_drain: got %h want %h", data0, d);
        end
      end
      @(negedge clk);
    end
    ready = 1'b0;
    checks++;
    if (npop !== 4) begin
      errors++;
      $display("FAIL full_pops: got %0d want 4", npop);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int n, npop;
    for (int it = 0; it < 5; it++) begin
      q.delete();
      npop = 0;
      ready = 1'b0;
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
        q.push_back(d);
      end
      repeat (BAUD) @(negedge clk);
      checks++;
      if (int'(cnt0) !== n) begin
        errors++;
        $display("FAIL b2b_count: got %0d want %0d", cnt0, n);
      end
      for (int c = 0; c < 40; c++) begin
        ready = 1'($urandom_range(0, 1));
        if (valid0 && ready) begin
          npop++;
          d = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++;
          if (data0 !== d) begin
            errors++;
            $display("FAIL b2b_data: got %h want %h", data0, d);
          end
        end
        @(negedge clk);
      end
      ready = 1'b1;
      while (valid0 && npop < 8) begin
        npop++;
        d = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++;
        if (data0 !== d) begin
          errors++;
          $display("FAIL b2b_tail: got %h want %h", data0, d);
        end
        @(negedge clk);
      end
      ready = 1'b0;
      checks++;
      if (npop !== n || ov0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pops: got %0d ov=%b want %0d/0",
                 npop, ov0, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_overflow();
    test_framing();
    test_parity();
    test_reset_mid();
    test_full_pop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
